// File: rtl/uart_param.sv
// Parametrised UART: shared baud tick generator, TX FIFO + serialiser,
// 16x-oversampling receiver with parity/framing/overrun reporting.
module uart_param #(
   parameter int unsigned RX_DIV     = 27,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk_50m,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] din,
   input  logic                 wr_en,
   output logic                 tx_full,
   output logic                 tx_busy,
   output logic                 tx,
   input  logic                 rx,
   input  logic                 rdy_clr,
   output logic                 rdy,
   output logic [DATA_BITS-1:0] dout,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int unsigned DIV_W = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PAR, TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
   } rx_state_t;

   function automatic logic par_of(input logic [DATA_BITS-1:0] d);
      if (PARITY == 1) return ~^d;
      return ^d;
   endfunction

   // ---------------- baud ticks ----------------
   logic [DIV_W-1:0] div_cnt;
   logic [3:0]       tx_sub;
   logic             os_tick;
   logic             tx_tick;

   assign os_tick = (div_cnt == DIV_W'(RX_DIV - 1));
   assign tx_tick = os_tick && (tx_sub == 4'd15);

   // free-running oversample divider and 16:1 bit-tick prescaler
   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         div_cnt <= '0;
         tx_sub  <= '0;
      end else begin
         div_cnt <= os_tick ? '0 : div_cnt + DIV_W'(1);
         if (os_tick) tx_sub <= tx_sub + 4'd1;
      end
   end

   // ---------------- TX FIFO ----------------
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;
   logic                 fifo_empty;
   logic                 push;
   logic                 pop;
   logic                 fifo_wr;
   logic                 fifo_rd;
   logic                 tx_ready;
   logic [DATA_BITS-1:0] pop_data;

   assign tx_full    = (count == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign push       = wr_en && !tx_full;
   assign pop        = tx_ready && (!fifo_empty || push);
   // an empty FIFO hands a fresh push straight to the serialiser
   assign fifo_wr    = push && !(pop && fifo_empty);
   assign fifo_rd    = pop && !fifo_empty;
   assign pop_data   = fifo_empty ? din : mem[rd_ptr];

   // FIFO storage (no reset needed, validity tracked by count)
   always_ff @(posedge clk_50m) begin
      if (fifo_wr) mem[wr_ptr] <= din;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         if (fifo_wr && !fifo_rd)      count <= count + CNT_W'(1);
         else if (fifo_rd && !fifo_wr) count <= count - CNT_W'(1);
      end
   end

   // ---------------- TX serialiser ----------------
   tx_state_t            tx_state;
   tx_state_t            tx_state_nxt;
   logic [DATA_BITS-1:0] tx_shift;
   logic                 tx_par;
   logic [3:0]           tx_cnt;
   logic                 tx_stop_done;

   assign tx_stop_done = (tx_state == TX_STOP) && tx_tick && (tx_cnt == 4'(STOP_BITS - 1));
   // the last stop interval may reload directly so frames run back-to-back
   assign tx_ready     = (tx_state == TX_IDLE) || tx_stop_done;

   // TX state register
   always_ff @(posedge clk_50m) begin
      if (!rst_n) tx_state <= TX_IDLE;
      else        tx_state <= tx_state_nxt;
   end

   // TX shift register, parity bit and bit/stop counter
   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         tx_shift <= '0;
         tx_par   <= 1'b0;
         tx_cnt   <= '0;
      end else if (pop) begin
         tx_shift <= pop_data;
         tx_par   <= par_of(pop_data);
         tx_cnt   <= '0;
      end else if (tx_tick) begin
         case (tx_state)
            TX_DATA: begin
               tx_shift <= tx_shift >> 1;
               tx_cnt   <= (tx_cnt == 4'(DATA_BITS - 1)) ? '0 : tx_cnt + 4'd1;
            end
            TX_STOP: tx_cnt <= tx_cnt + 4'd1;
            default: tx_cnt <= '0;
         endcase
      end
   end

   // TX next state and line/busy outputs
   always_comb begin
      tx_state_nxt = tx_state;
      tx           = 1'b1;
      tx_busy      = !fifo_empty || (tx_state != TX_IDLE);
      case (tx_state)
         TX_IDLE:  if (pop) tx_state_nxt = TX_WAIT;
         TX_WAIT:  if (tx_tick) tx_state_nxt = TX_START;
         TX_START: begin
            tx = 1'b0;
            if (tx_tick) tx_state_nxt = TX_DATA;
         end
         TX_DATA: begin
            tx = tx_shift[0];
            if (tx_tick && (tx_cnt == 4'(DATA_BITS - 1)))
               tx_state_nxt = (PARITY != 0) ? TX_PAR : TX_STOP;
         end
         TX_PAR: begin
            tx = tx_par;
            if (tx_tick) tx_state_nxt = TX_STOP;
         end
         TX_STOP:  if (tx_stop_done) tx_state_nxt = pop ? TX_START : TX_IDLE;
         default:  tx_state_nxt = TX_IDLE;
      endcase
   end

   // ---------------- RX path ----------------
   logic                 rx_m;
   logic                 rx_s;
   rx_state_t            rx_state;
   rx_state_t            rx_state_nxt;
   logic [3:0]           rx_os;
   logic [3:0]           rx_bit;
   logic [DATA_BITS-1:0] rx_shift;
   logic                 rx_par;
   logic                 rx_mid;
   logic                 rx_stop_sample;
   logic                 rx_perr;

   assign rx_mid         = os_tick && (rx_os == 4'd15);
   assign rx_stop_sample = (rx_state == RX_STOP) && rx_mid;
   assign rx_perr        = (PARITY != 0) && (rx_par != par_of(rx_shift));

   // two-flop synchroniser for the asynchronous line
   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // RX state register
   always_ff @(posedge clk_50m) begin
      if (!rst_n) rx_state <= RX_IDLE;
      else        rx_state <= rx_state_nxt;
   end

   // RX next state
   always_comb begin
      rx_state_nxt = rx_state;
      case (rx_state)
         RX_IDLE:  if (os_tick && !rx_s) rx_state_nxt = RX_START;
         RX_START: if (os_tick && (rx_os == 4'd7)) rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_mid && (rx_bit == 4'(DATA_BITS - 1)))
                      rx_state_nxt = (PARITY != 0) ? RX_PAR : RX_STOP;
         RX_PAR:   if (rx_mid) rx_state_nxt = RX_STOP;
         RX_STOP:  if (rx_mid) rx_state_nxt = RX_IDLE;
         default:  rx_state_nxt = RX_IDLE;
      endcase
   end

   // oversample counter, bit counter and mid-bit sampling
   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         rx_os    <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_par   <= 1'b0;
      end else if (os_tick) begin
         case (rx_state)
            RX_IDLE:  rx_os <= '0;
            RX_START: begin
               rx_os  <= (rx_os == 4'd7) ? '0 : rx_os + 4'd1;
               rx_bit <= '0;
            end
            RX_DATA: begin
               rx_os <= rx_os + 4'd1;
               if (rx_os == 4'd15) begin
                  rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                  rx_bit   <= rx_bit + 4'd1;
               end
            end
            RX_PAR: begin
               rx_os <= rx_os + 4'd1;
               if (rx_os == 4'd15) rx_par <= rx_s;
            end
            default:  rx_os <= rx_os + 4'd1;
         endcase
      end
   end

   // host-side word/flag registers; a completing word beats rdy_clr
   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         rdy        <= 1'b0;
         dout       <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else if (rx_stop_sample) begin
         rdy        <= 1'b1;
         dout       <= rx_shift;
         parity_err <= rx_perr;
         frame_err  <= !rx_s;
         overrun    <= rdy_clr ? 1'b0 : (overrun | rdy);
      end else if (rdy_clr) begin
         rdy        <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param: one no-parity and one even-parity instance.
module tb_uart_param;

   logic       clk;
   logic       rst_n;

   logic [7:0] din_d, dout_d;
   logic       wr_en_d, tx_full_d, tx_busy_d, tx_d, rx_d, rdy_clr_d, rdy_d;
   logic       perr_d, ferr_d, ovr_d, loop_d;

   logic [7:0] din_p, dout_p;
   logic       wr_en_p, tx_full_p, tx_busy_p, tx_p, rx_p, rdy_clr_p, rdy_p;
   logic       perr_p, ferr_p, ovr_p, loop_p, rx_drv;

   int total;
   int bad;

   typedef struct {
      logic [7:0] d;
      logic       bad_par;
      logic       stop;
      logic       exp_perr;
      logic       exp_ferr;
   } rx_vec_t;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign rx_d = loop_d ? tx_d : 1'b1;
   assign rx_p = loop_p ? tx_p : rx_drv;

   uart_param #(.RX_DIV(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
      .clk_50m(clk), .rst_n(rst_n), .din(din_d), .wr_en(wr_en_d), .tx_full(tx_full_d),
      .tx_busy(tx_busy_d), .tx(tx_d), .rx(rx_d), .rdy_clr(rdy_clr_d), .rdy(rdy_d),
      .dout(dout_d), .parity_err(perr_d), .frame_err(ferr_d), .overrun(ovr_d)
   );

   uart_param #(.RX_DIV(2), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_par (
      .clk_50m(clk), .rst_n(rst_n), .din(din_p), .wr_en(wr_en_p), .tx_full(tx_full_p),
      .tx_busy(tx_busy_p), .tx(tx_p), .rx(rx_p), .rdy_clr(rdy_clr_p), .rdy(rdy_p),
      .dout(dout_p), .parity_err(perr_p), .frame_err(ferr_p), .overrun(ovr_p)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // wait (bounded) until the selected transmitter drives its start bit
   task automatic wait_tx_low(input logic sel, output logic found);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if ((sel ? tx_p : tx_d) == 1'b0) found = 1'b1;
         else @(negedge clk);
      end
   endtask

   // bit-bang one 11-bit frame into u_par; optionally pulse rdy_clr at cycle clr_at
   task automatic rx_frame(input logic [7:0] d, input logic bad_par, input logic stop_bit,
                           input int clr_at, output int chg_at);
      logic [10:0] bits;
      logic [7:0]  prev;
      bits   = {stop_bit, (^d) ^ bad_par, d, 1'b0};
      chg_at = -1;
      prev   = dout_p;
      for (int i = 0; i < 392; i++) begin
         @(negedge clk);
         if (dout_p !== prev && chg_at < 0) chg_at = i;
         prev      = dout_p;
         rx_drv    = (i < 352) ? bits[i/32] : 1'b1;
         rdy_clr_p = (i == clr_at);
      end
      rdy_clr_p = 1'b0;
   endtask

   initial begin
      rx_vec_t    vecs [5];
      logic [7:0] fifo_w [6];
      logic [7:0] got [8];
      int         t_rx [8];
      logic [9:0] exp_bits;
      int         n_rx, chg, chg2, lows;
      logic       found;

      vecs[0] = '{8'h07, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
      fifo_w[0] = 8'h11; fifo_w[1] = 8'h22; fifo_w[2] = 8'h33;
      fifo_w[3] = 8'h44; fifo_w[4] = 8'h55; fifo_w[5] = 8'h66;
      for (int i = 0; i < 8; i++) begin
         got[i]  = 8'h00;
         t_rx[i] = 0;
      end
      total = 0; bad = 0;

      rst_n = 1'b0;
      din_d = 8'h00; wr_en_d = 1'b0; rdy_clr_d = 1'b0; loop_d = 1'b0;
      din_p = 8'h00; wr_en_p = 1'b0; rdy_clr_p = 1'b0; loop_p = 1'b0; rx_drv = 1'b1;
      repeat (4) @(negedge clk);

      // reset state
      check("rst_tx", 32'(tx_d), 32'(1));
      check("rst_busy", 32'(tx_busy_d), 32'(0));
      check("rst_full", 32'(tx_full_d), 32'(0));
      check("rst_rdy", 32'(rdy_d), 32'(0));
      check("rst_dout", 32'(dout_d), 32'(0));
      check("rst_flags", 32'({perr_p, ferr_p, ovr_p, perr_d, ferr_d, ovr_d}), 32'(0));
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // single word 8'hA5 on the wire
      exp_bits = {1'b1, 8'hA5, 1'b0};
      din_d = 8'hA5; wr_en_d = 1'b1;
      @(negedge clk);
      wr_en_d = 1'b0;
      check("a5_busy", 32'(tx_busy_d), 32'(1));
      wait_tx_low(1'b0, found);
      check("a5_start_seen", 32'(found), 32'(1));
      for (int i = 1; i <= 320; i++) begin
         @(negedge clk);
         if (i == 31) check("a5_start_len", 32'(tx_d), 32'(0));
         if (i == 32) check("a5_bit0_edge", 32'(tx_d), 32'(1));
         if (i % 32 == 16) check("a5_wire_bit", 32'(tx_d), 32'(exp_bits[i/32]));
         if (i == 319) check("a5_busy_stop", 32'(tx_busy_d), 32'(1));
         if (i == 320) begin
            check("a5_busy_done", 32'(tx_busy_d), 32'(0));
            check("a5_idle", 32'(tx_d), 32'(1));
         end
      end

      // FIFO fill, drop on full, loopback back-to-back
      loop_d = 1'b1;
      for (int i = 0; i < 5; i++) begin
         din_d = fifo_w[i]; wr_en_d = 1'b1;
         @(negedge clk);
         if (i == 0) check("fifo_full_after1", 32'(tx_full_d), 32'(0));
      end
      check("fifo_full_after5", 32'(tx_full_d), 32'(1));
      din_d = fifo_w[5];
      @(negedge clk);
      wr_en_d = 1'b0;
      check("fifo_full_after6", 32'(tx_full_d), 32'(1));
      n_rx = 0;
      for (int c = 0; c < 2400; c++) begin
         @(negedge clk);
         if (rdy_d) begin
            if (n_rx < 8) begin
               got[n_rx]  = dout_d;
               t_rx[n_rx] = c;
            end
            n_rx++;
            rdy_clr_d = 1'b1;
         end else begin
            rdy_clr_d = 1'b0;
         end
      end
      rdy_clr_d = 1'b0;
      check("fifo_rx_count", 32'(n_rx), 32'(5));
      for (int i = 0; i < 5; i++) check("fifo_rx_word", 32'(got[i]), 32'(fifo_w[i]));
      for (int i = 1; i < 5; i++) check("fifo_rx_spacing", 32'(t_rx[i] - t_rx[i-1]), 32'(320));
      check("fifo_busy_end", 32'(tx_busy_d), 32'(0));
      check("fifo_flags_end", 32'({perr_d, ferr_d, ovr_d}), 32'(0));

      // even-parity loopback of 8'h07
      loop_p = 1'b1;
      din_p = 8'h07; wr_en_p = 1'b1;
      @(negedge clk);
      wr_en_p = 1'b0;
      wait_tx_low(1'b1, found);
      check("par_start_seen", 32'(found), 32'(1));
      repeat (9 * 32 + 16) @(negedge clk);
      check("par_wire_bit", 32'(tx_p), 32'(1));
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (rdy_p) found = 1'b1;
         else @(negedge clk);
      end
      check("par_loop_rdy", 32'(found), 32'(1));
      check("par_loop_dout", 32'(dout_p), 32'(8'h07));
      check("par_loop_perr", 32'(perr_p), 32'(0));
      repeat (40) @(negedge clk);
      loop_p = 1'b0;
      rdy_clr_p = 1'b1;
      @(negedge clk);
      rdy_clr_p = 1'b0;

      // table of injected frames
      for (int v = 0; v < 5; v++) begin
         rx_frame(vecs[v].d, vecs[v].bad_par, vecs[v].stop, -1, chg);
         check("vec_rdy", 32'(rdy_p), 32'(1));
         check("vec_dout", 32'(dout_p), 32'(vecs[v].d));
         check("vec_perr", 32'(perr_p), 32'(vecs[v].exp_perr));
         check("vec_ferr", 32'(ferr_p), 32'(vecs[v].exp_ferr));
         check("vec_ovr", 32'(ovr_p), 32'(0));
         rdy_clr_p = 1'b1;
         @(negedge clk);
         rdy_clr_p = 1'b0;
         check("vec_clr_rdy", 32'(rdy_p), 32'(0));
         check("vec_clr_flags", 32'({perr_p, ferr_p, ovr_p}), 32'(0));
      end

      // overrun, then rdy_clr landing on the STOP sample
      rx_frame(8'h12, 1'b0, 1'b1, -1, chg);
      check("ovr_w1", 32'(ovr_p), 32'(0));
      rx_frame(8'h34, 1'b0, 1'b1, -1, chg2);
      check("ovr_w2_chg_seen", 32'(chg2 > 0), 32'(1));
      check("ovr_w2_ovr", 32'(ovr_p), 32'(1));
      check("ovr_w2_dout", 32'(dout_p), 32'(8'h34));
      check("ovr_w2_rdy", 32'(rdy_p), 32'(1));
      rx_frame(8'h56, 1'b0, 1'b1, chg2 - 1, chg);
      check("ovr_w3_rdy", 32'(rdy_p), 32'(1));
      check("ovr_w3_ovr", 32'(ovr_p), 32'(0));
      check("ovr_w3_dout", 32'(dout_p), 32'(8'h56));
      check("ovr_w3_flags", 32'({perr_p, ferr_p}), 32'(0));
      rdy_clr_p = 1'b1;
      @(negedge clk);
      rdy_clr_p = 1'b0;
      check("ovr_clr_rdy", 32'(rdy_p), 32'(0));

      // short low glitch on rx
      rx_drv = 1'b0;
      repeat (8) @(negedge clk);
      rx_drv = 1'b1;
      repeat (100) @(negedge clk);
      check("glitch_rdy", 32'(rdy_p), 32'(0));
      check("glitch_flags", 32'({perr_p, ferr_p, ovr_p}), 32'(0));
      check("glitch_dout", 32'(dout_p), 32'(8'h56));

      // reset in the middle of a TX frame
      loop_d = 1'b0;
      for (int i = 0; i < 3; i++) begin
         din_d = fifo_w[i]; wr_en_d = 1'b1;
         @(negedge clk);
      end
      wr_en_d = 1'b0;
      wait_tx_low(1'b0, found);
      check("rst_mid_start_seen", 32'(found), 32'(1));
      repeat (50) @(negedge clk);
      check("rst_mid_busy_before", 32'(tx_busy_d), 32'(1));
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_tx", 32'(tx_d), 32'(1));
      check("rst_mid_busy", 32'(tx_busy_d), 32'(0));
      check("rst_mid_full", 32'(tx_full_d), 32'(0));
      check("rst_mid_dout_p", 32'(dout_p), 32'(0));
      rst_n = 1'b1;
      lows = 0;
      repeat (400) begin
         @(negedge clk);
         if (tx_d == 1'b0 || tx_busy_d) lows++;
      end
      check("rst_mid_quiet", 32'(lows), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
- Parametrised next-generation UART: configurable data width, parity and stop bits, a TX FIFO, and RX error reporting (parity, framing, overrun).
- One system clock drives a shared baud tick generator, a TX path (FIFO + serialiser) and a 16x-oversampling RX path.
- Drop-in successor for simple byte-wide serial links; the host side uses the same wr_en/tx_busy and rdy/rdy_clr handshakes.

Parameters:
- RX_DIV, 27, clk_50m cycles per 16x oversample tick (27 gives ~115200 baud at 50 MHz); must be >= 2; one bit period = 16*RX_DIV cycles.
- DATA_BITS, 8, payload bits per frame, 5..8.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits transmitted, 1 or 2; RX checks only the first.
- FIFO_DEPTH, 4, TX FIFO entries, power of two, >= 2.

Ports:
- clk_50m  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- din  input  DATA_BITS  TX data, written when wr_en=1.
- wr_en  input  1  push din into TX FIFO; ignored when tx_full=1.
- tx_full  output  1  TX FIFO full.
- tx_busy  output  1  FIFO non-empty or a frame is being shifted.
- tx  output  1  serial out, idle high.
- rx  input  1  serial in, asynchronous.
- rdy_clr  input  1  clear rdy and all error flags.
- rdy  output  1  received word valid in dout.
- dout  output  DATA_BITS  last received word.
- parity_err  output  1  parity mismatch on last word (always 0 when PARITY=0).
- frame_err  output  1  first stop bit sampled low.
- overrun  output  1  a word completed while rdy was already 1.

Behaviour:
- Reset (rst_n=0 at edge): tx=1, tx_busy=0, tx_full=0, FIFO empty, rdy=0, dout=0, all error flags 0, tick counters 0, both FSMs IDLE. A reset mid-frame aborts it; tx is high on the next cycle.
- Baud: os_tick pulses 1 cycle every RX_DIV cycles, free-running from reset. tx_tick = every 16th os_tick.
- TX FIFO:
  - A push happens when wr_en=1 and tx_full=0.
  - A pop happens when the serialiser is in IDLE and the FIFO is non-empty; a word pushed into an empty FIFO reaches the serialiser in the same cycle.
  - Push and pop on the same cycle are legal and leave the count unchanged.
  - wr_en while full is dropped, with no state change.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - A popped word is loaded into the shift register. START begins on the next tx_tick, driving tx=0.
  - Each state lasts one tx_tick interval. DATA shifts out DATA_BITS LSB-first.
  - PARITY drives: odd = ~^data, even = ^data.
  - STOP holds tx=1 for STOP_BITS intervals.
  - Frames from the FIFO go back-to-back with no extra idle bit.
- tx_busy = (FIFO count != 0) | (FSM != IDLE).
- RX input: rx passes through a 2-flop synchroniser (rx_s) before any use.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE. All sampling occurs on os_tick.
  - IDLE: rx_s=0 enters START with the sample count cleared.
  - START: at the 8th os_tick, if rx_s=1 it is a glitch and the FSM returns to IDLE with no flags; otherwise the count resets.
  - DATA, PARITY and STOP each sample rx_s at the 16th os_tick, i.e. mid-bit. Data is shifted LSB-first.
  - STOP sample:
    - dout <= received word, rdy <= 1.
    - parity_err <= computed mismatch.
    - frame_err <= ~stop_sample.
    - overrun <= overrun | rdy_old.
    - The FSM returns to IDLE immediately; the second stop bit is not awaited.
- Overrun rule: the new word overwrites dout. parity_err and frame_err reflect the newest word.
- rdy_clr clears rdy, parity_err, frame_err and overrun on the next edge. If rdy_clr coincides with a STOP sample, the new word wins: rdy=1, flags loaded from the new word, overrun=0.
- The TX and RX paths are fully independent; loopback (tx tied to rx) is legal.

Test Plan:
- RX_DIV=2, defaults; reset, push 8'hA5 -> tx low for 32 cycles, then bits 1,0,1,0,0,1,0,1 at 32 cycles each, then high; tx_busy drops after the stop bit.
- FIFO_DEPTH=4, push 5 words on consecutive cycles while idle -> first word popped at once, 4 buffered, tx_full=1 after the 5th push; a 6th push is dropped. Loopback receives exactly 5 words, back-to-back, in order.
- PARITY=2, loopback 8'h07 -> parity bit 1 on the wire; rdy=1, dout=8'h07, parity_err=0. Force a wrong parity bit on rx -> parity_err=1.
- Drive rx stop bit low on word 8'h3C -> rdy=1, dout=8'h3C, frame_err=1. Then rdy_clr -> all flags 0 next cycle.
- Receive two words without rdy_clr -> overrun=1, dout = second word. Then assert rdy_clr exactly on the 3rd word's STOP sample -> rdy=1, overrun=0.
- rx low pulse of 4*RX_DIV cycles -> no rdy, no flags. Assert rst_n=0 mid-TX-frame -> tx=1, tx_busy=0, FIFO empty on the next cycle.
